// File: rtl/hp_axi_arbiter_pkg.sv
// Shared types and AXI constants for the two-requester HP-port arbiter.
package hp_axi_arbiter_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ID_W    = 6;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic       AX_LOCK    = 1'b0;
    localparam logic [3:0] AX_CACHE   = 4'h0;
    localparam logic [2:0] AX_PROT    = 3'h0;
    localparam logic [3:0] AX_QOS     = 4'h0;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_DATA = 1'b1
    } wstate_e;

    // AXI AxSIZE encoding for a bus of the given byte width.
    function automatic logic [2:0] axi_size(input int unsigned bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage

// File: rtl/hp_axi_arbiter_rr_arb.sv
// Two-way request arbiter whose grant is frozen while its valid is stalled.
// Round-robin priority when HP_AXI_ARB_ROUND_ROBIN_EN is defined, else requester 0 wins.
module hp_axi_rr_arb (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic       gnt_o
);

    logic lock_q, lock_d;
    logic lock_idx_q, lock_idx_d;
    logic pick_c;
    logic hs_c;

    assign valid_o = en_i & (|req_i);
    assign gnt_o   = lock_q ? lock_idx_q : pick_c;
    assign hs_c    = valid_o & ready_i;

`ifdef HP_AXI_ARB_ROUND_ROBIN_EN
    // prio_q names the requester with highest priority this round.
    logic prio_q, prio_d;

    always_comb begin
        pick_c = prio_q ? req_i[1] : ~req_i[0];
    end

    always_comb begin
        prio_d = prio_q;
        if (hs_c) begin
            prio_d = ~gnt_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    always_comb begin
        pick_c = ~req_i[0];
    end
`endif

    // Hold the presented grant until the downstream accepts it.
    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (hs_c) begin
            lock_d = 1'b0;
        end else if (valid_o) begin
            lock_d     = 1'b1;
            lock_idx_d = gnt_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q     <= 1'b0;
            lock_idx_q <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: rtl/hp_axi_arbiter.sv
// Merges two AXI4 requesters onto one HP master port; writes serialised per burst, reads routed by ID.
// Optional build macro: HP_AXI_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module hp_axi_arbiter
    import hp_axi_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                          aclk,
    input  logic                          areset,

    input  logic [NUM_REQ-1:0]            s_awvalid,
    input  logic [NUM_REQ*ADDR_W-1:0]     s_awaddr,
    input  logic [NUM_REQ*8-1:0]          s_awlen,
    output logic [NUM_REQ-1:0]            s_awready,
    input  logic [NUM_REQ-1:0]            s_wvalid,
    input  logic [NUM_REQ*DATA_W-1:0]     s_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0]   s_wstrb,
    input  logic [NUM_REQ-1:0]            s_wlast,
    output logic [NUM_REQ-1:0]            s_wready,
    output logic [NUM_REQ-1:0]            s_bvalid,
    output logic [NUM_REQ*2-1:0]          s_bresp,
    input  logic [NUM_REQ-1:0]            s_bready,
    input  logic [NUM_REQ-1:0]            s_arvalid,
    input  logic [NUM_REQ*ADDR_W-1:0]     s_araddr,
    input  logic [NUM_REQ*8-1:0]          s_arlen,
    output logic [NUM_REQ-1:0]            s_arready,
    output logic [NUM_REQ-1:0]            s_rvalid,
    output logic [NUM_REQ*DATA_W-1:0]     s_rdata,
    output logic [NUM_REQ*2-1:0]          s_rresp,
    output logic [NUM_REQ-1:0]            s_rlast,
    input  logic [NUM_REQ-1:0]            s_rready,

    output logic [ID_W-1:0]               m_awid,
    output logic [ADDR_W-1:0]             m_awaddr,
    output logic [7:0]                    m_awlen,
    output logic [2:0]                    m_awsize,
    output logic [1:0]                    m_awburst,
    output logic                          m_awlock,
    output logic [3:0]                    m_awcache,
    output logic [2:0]                    m_awprot,
    output logic [3:0]                    m_awqos,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [DATA_W-1:0]             m_wdata,
    output logic [DATA_W/8-1:0]           m_wstrb,
    output logic                          m_wlast,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    input  logic [ID_W-1:0]               m_bid,
    input  logic [1:0]                    m_bresp,
    input  logic                          m_bvalid,
    output logic                          m_bready,
    output logic [ID_W-1:0]               m_arid,
    output logic [ADDR_W-1:0]             m_araddr,
    output logic [7:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    output logic                          m_arlock,
    output logic [3:0]                    m_arcache,
    output logic [2:0]                    m_arprot,
    output logic [3:0]                    m_arqos,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [ID_W-1:0]               m_rid,
    input  logic [DATA_W-1:0]             m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    input  logic                          m_rvalid,
    output logic                          m_rready
);

    localparam int unsigned    STRB_W  = DATA_W / 8;
    localparam int unsigned    CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [2:0]     AXSIZE  = axi_size(STRB_W);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    wstate_e          state_q, state_d;
    logic             w_sel_q, w_sel_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

    logic aw_en_c, aw_valid_c, aw_gnt_c, aw_hs_c;
    logic w_last_hs_c, b_hs_c;
    logic ar_valid_c, ar_gnt_c, ar_hs_c;
    logic unused_id_bits_c;

    assign unused_id_bits_c = ^{m_bid[ID_W-1:1], m_rid[ID_W-1:1]};

    // ---------------- write address ----------------
    assign aw_en_c = ~areset && (state_q == W_IDLE) && (out_cnt_q < MAX_CNT);

    hp_axi_rr_arb u_aw_arb (
        .clk_i   (aclk),
        .rst_i   (areset),
        .req_i   (s_awvalid),
        .en_i    (aw_en_c),
        .ready_i (m_awready),
        .valid_o (aw_valid_c),
        .gnt_o   (aw_gnt_c)
    );

    assign aw_hs_c   = aw_valid_c & m_awready;
    assign m_awvalid = aw_valid_c;
    assign m_awid    = {{(ID_W-1){1'b0}}, aw_gnt_c};
    assign m_awaddr  = aw_gnt_c ? s_awaddr[2*ADDR_W-1:ADDR_W] : s_awaddr[ADDR_W-1:0];
    assign m_awlen   = aw_gnt_c ? s_awlen[15:8] : s_awlen[7:0];
    assign m_awsize  = AXSIZE;
    assign m_awburst = BURST_INCR;
    assign m_awlock  = AX_LOCK;
    assign m_awcache = AX_CACHE;
    assign m_awprot  = AX_PROT;
    assign m_awqos   = AX_QOS;

    // ---------------- write FSM ----------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= W_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            W_IDLE:  if (aw_hs_c)     state_d = W_DATA;
            W_DATA:  if (w_last_hs_c) state_d = W_IDLE;
            default: state_d = W_IDLE;
        endcase
    end

    always_comb begin
        s_awready = '0;
        s_wready  = '0;
        m_wvalid  = 1'b0;
        m_wdata   = w_sel_q ? s_wdata[2*DATA_W-1:DATA_W] : s_wdata[DATA_W-1:0];
        m_wstrb   = w_sel_q ? s_wstrb[2*STRB_W-1:STRB_W] : s_wstrb[STRB_W-1:0];
        m_wlast   = s_wlast[w_sel_q];
        case (state_q)
            W_IDLE: begin
                s_awready[aw_gnt_c] = aw_hs_c;
            end
            W_DATA: begin
                m_wvalid          = s_wvalid[w_sel_q];
                s_wready[w_sel_q] = m_wready;
            end
            default: ;
        endcase
    end

    assign w_last_hs_c = m_wvalid & m_wready & m_wlast;

    // ---------------- W owner and outstanding count ----------------
    always_comb begin
        w_sel_d = w_sel_q;
        if (aw_hs_c) begin
            w_sel_d = aw_gnt_c;
        end
    end

    always_comb begin
        out_cnt_d = out_cnt_q;
        case ({aw_hs_c, b_hs_c})
            2'b10:   if (out_cnt_q < MAX_CNT)     out_cnt_d = out_cnt_q + CNT_W'(1);
            2'b01:   if (out_cnt_q != CNT_W'(0))  out_cnt_d = out_cnt_q - CNT_W'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_sel_q   <= 1'b0;
            out_cnt_q <= '0;
        end else begin
            w_sel_q   <= w_sel_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // ---------------- write response routing ----------------
    assign m_bready = ~areset & s_bready[m_bid[0]];
    assign b_hs_c   = m_bvalid & m_bready;
    assign s_bresp  = {NUM_REQ{m_bresp}};

    always_comb begin
        s_bvalid           = '0;
        s_bvalid[m_bid[0]] = m_bvalid & ~areset;
    end

    // ---------------- read address ----------------
    hp_axi_rr_arb u_ar_arb (
        .clk_i   (aclk),
        .rst_i   (areset),
        .req_i   (s_arvalid),
        .en_i    (~areset),
        .ready_i (m_arready),
        .valid_o (ar_valid_c),
        .gnt_o   (ar_gnt_c)
    );

    assign ar_hs_c   = ar_valid_c & m_arready;
    assign m_arvalid = ar_valid_c;
    assign m_arid    = {{(ID_W-1){1'b0}}, ar_gnt_c};
    assign m_araddr  = ar_gnt_c ? s_araddr[2*ADDR_W-1:ADDR_W] : s_araddr[ADDR_W-1:0];
    assign m_arlen   = ar_gnt_c ? s_arlen[15:8] : s_arlen[7:0];
    assign m_arsize  = AXSIZE;
    assign m_arburst = BURST_INCR;
    assign m_arlock  = AX_LOCK;
    assign m_arcache = AX_CACHE;
    assign m_arprot  = AX_PROT;
    assign m_arqos   = AX_QOS;

    always_comb begin
        s_arready           = '0;
        s_arready[ar_gnt_c] = ar_hs_c;
    end

    // ---------------- read data routing ----------------
    assign m_rready = ~areset & s_rready[m_rid[0]];
    assign s_rdata  = {NUM_REQ{m_rdata}};
    assign s_rresp  = {NUM_REQ{m_rresp}};
    assign s_rlast  = {NUM_REQ{m_rlast}};

    always_comb begin
        s_rvalid           = '0;
        s_rvalid[m_rid[0]] = m_rvalid & ~areset;
    end

endmodule

// File: tb/tb_hp_axi_arbiter.sv
// Directed self-checking bench for hp_axi_arbiter (default parameters).
module tb_hp_axi_arbiter;
    import hp_axi_arbiter_pkg::*;

    logic        aclk;
    logic        areset;
    logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wlast, s_wready;
    logic [63:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [15:0] s_awlen, s_arlen;
    logic [7:0]  s_wstrb;
    logic [1:0]  s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
    logic [3:0]  s_bresp, s_rresp;
    logic [5:0]  m_awid, m_bid, m_arid, m_rid;
    logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
    logic [7:0]  m_awlen, m_arlen;
    logic [2:0]  m_awsize, m_arsize, m_awprot, m_arprot;
    logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;
    logic        m_awlock, m_arlock;
    logic [3:0]  m_awcache, m_arcache, m_awqos, m_arqos, m_wstrb;
    logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
    logic        m_bvalid, m_bready, m_arvalid, m_arready;
    logic        m_rlast, m_rvalid, m_rready;

    int checks;
    int failures;

    hp_axi_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(4)) dut (
        .aclk(aclk), .areset(areset),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rready(s_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
        .m_awqos(m_awqos), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arqos(m_arqos), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic test_reset();
        areset = 1'b1;
        s_awvalid = '0; s_awaddr = '0; s_awlen = '0;
        s_wvalid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0;
        s_bready = '0; s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_rready = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
        m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
        repeat (2) @(negedge aclk);
        #1;
        checks++;
        if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 5'b0) begin
            failures++;
            $display("FAIL reset_m_valids got=%b exp=00000", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready});
        end
        checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 10'b0) begin
            failures++;
            $display("FAIL reset_s_readys got=%b exp=0", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
        end
        checks++;
        if (dut.out_cnt_q !== 3'd0 || dut.state_q !== W_IDLE) begin
            failures++;
            $display("FAIL reset_state got=cnt%0d st%0d exp=cnt0 st0", dut.out_cnt_q, dut.state_q);
        end
        @(negedge aclk);
        areset = 1'b0;
    endtask

    // Both requesters post AW len=3; req0 burst must finish before req1 AW.
    task automatic test_write_arb();
        @(negedge aclk);
        s_awaddr = {32'h0000_2000, 32'h0000_1000};
        s_awlen = {8'd3, 8'd3};
        s_awvalid = 2'b11;
        m_awready = 1'b1;
        #1;
        checks++;
        if ({m_awvalid, m_awid, m_awaddr, m_awlen, s_awready} !== {1'b1, 6'd0, 32'h1000, 8'd3, 2'b01}) begin
            failures++;
            $display("FAIL aw0 got=v%b id%0d a%h l%0d r%b exp=v1 id0 a1000 l3 r01",
                     m_awvalid, m_awid, m_awaddr, m_awlen, s_awready);
        end
        checks++;
        if ({m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awqos} !==
            {3'd2, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0}) begin
            failures++;
            $display("FAIL aw_const got=sz%0d b%0d lk%b c%0d p%0d q%0d exp=sz2 b1 0 0 0 0",
                     m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awqos);
        end
        @(negedge aclk);
        s_awvalid = 2'b10;
        s_wvalid = 2'b11;
        m_wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_wdata = {32'hDEAD_BEEF, 32'hA000_0000 + 32'(i)};
            s_wstrb = {4'hF, 4'h5};
            s_wlast = {1'b0, (i == 3)};
            #1;
            checks++;
            if ({m_wvalid, s_wready, m_awvalid} !== {1'b1, 2'b01, 1'b0}) begin
                failures++;
                $display("FAIL w0_ctl beat%0d got=v%b r%b aw%b exp=v1 r01 aw0", i, m_wvalid, s_wready, m_awvalid);
            end
            checks++;
            if ({m_wdata, m_wstrb, m_wlast} !== {32'hA000_0000 + 32'(i), 4'h5, (i == 3)}) begin
                failures++;
                $display("FAIL w0_data beat%0d got=%h/%h/%b exp=%h/5/%b",
                         i, m_wdata, m_wstrb, m_wlast, 32'hA000_0000 + 32'(i), (i == 3));
            end
            @(negedge aclk);
        end
        s_wvalid = 2'b10;
        s_wlast = 2'b00;
        #1;
        checks++;
        if ({m_wvalid, m_awvalid, m_awid, m_awaddr, s_awready} !== {1'b0, 1'b1, 6'd1, 32'h2000, 2'b10}) begin
            failures++;
            $display("FAIL aw1 got=wv%b v%b id%0d a%h r%b exp=wv0 v1 id1 a2000 r10",
                     m_wvalid, m_awvalid, m_awid, m_awaddr, s_awready);
        end
        @(negedge aclk);
        s_awvalid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            s_wdata = {32'hB000_0000 + 32'(i), 32'h1234_5678};
            s_wstrb = {4'h3, 4'hF};
            s_wlast = {(i == 3), 1'b0};
            #1;
            checks++;
            if ({m_wvalid, s_wready, m_wdata, m_wstrb, m_wlast} !==
                {1'b1, 2'b10, 32'hB000_0000 + 32'(i), 4'h3, (i == 3)}) begin
                failures++;
                $display("FAIL w1 beat%0d got=v%b r%b %h/%h/%b exp=v1 r10 %h/3/%b",
                         i, m_wvalid, s_wready, m_wdata, m_wstrb, m_wlast, 32'hB000_0000 + 32'(i), (i == 3));
            end
            @(negedge aclk);
        end
        s_wvalid = 2'b00;
        s_wlast = 2'b00;
        #1;
        checks++;
        if (dut.out_cnt_q !== 3'd2 || dut.state_q !== W_IDLE) begin
            failures++;
            $display("FAIL wr_outstanding got=cnt%0d st%0d exp=cnt2 st0", dut.out_cnt_q, dut.state_q);
        end
    endtask

    // AW and B complete in the same cycle: count holds at 2.
    task automatic test_simultaneous();
        @(negedge aclk);
        s_awaddr = {32'h0, 32'h0000_3000};
        s_awlen = 16'h0000;
        s_awvalid = 2'b01;
        m_bvalid = 1'b1; m_bid = 6'd0; m_bresp = 2'b00; s_bready = 2'b01;
        #1;
        checks++;
        if ({m_awvalid, s_awready, m_bready, s_bvalid} !== {1'b1, 2'b01, 1'b1, 2'b01}) begin
            failures++;
            $display("FAIL simul_hs got=aw%b r%b br%b bv%b exp=aw1 r01 br1 bv01", m_awvalid, s_awready, m_bready, s_bvalid);
        end
        @(negedge aclk);
        s_awvalid = 2'b00; m_bvalid = 1'b0; s_bready = 2'b00;
        #1;
        checks++;
        if (dut.out_cnt_q !== 3'd2) begin
            failures++;
            $display("FAIL simul_cnt got=%0d exp=2", dut.out_cnt_q);
        end
        s_wvalid = 2'b01; s_wlast = 2'b01; s_wdata = {32'h0, 32'h0000_0C0C}; s_wstrb = 8'h0F;
        @(negedge aclk);
        s_wvalid = 2'b00; s_wlast = 2'b00;
    endtask

    // B routing by bid[0], then drain the two outstanding writes.
    task automatic test_b_route();
        @(negedge aclk);
        m_bvalid = 1'b1; m_bid = 6'd1; m_bresp = 2'b10; s_bready = 2'b01;
        #1;
        checks++;
        if ({s_bvalid, m_bready, s_bresp[3:2]} !== {2'b10, 1'b0, 2'b10}) begin
            failures++;
            $display("FAIL b_route1 got=bv%b br%b resp%b exp=bv10 br0 resp10", s_bvalid, m_bready, s_bresp[3:2]);
        end
        @(negedge aclk);
        s_bready = 2'b10;
        #1;
        checks++;
        if (m_bready !== 1'b1) begin
            failures++;
            $display("FAIL b_ready1 got=%b exp=1", m_bready);
        end
        @(negedge aclk);
        m_bid = 6'd0; s_bready = 2'b01;
        @(negedge aclk);
        m_bvalid = 1'b0; s_bready = 2'b00;
        #1;
        checks++;
        if (dut.out_cnt_q !== 3'd0) begin
            failures++;
            $display("FAIL b_drain got=%0d exp=0", dut.out_cnt_q);
        end
    endtask

    // Four single-beat writes fill the window; the fifth waits for a B.
    task automatic test_max_out();
        s_awaddr = {32'h0, 32'h0000_5000};
        s_awlen = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            s_awvalid = 2'b01;
            #1;
            checks++;
            if (m_awvalid !== 1'b1) begin
                failures++;
                $display("FAIL maxout_issue%0d got=%b exp=1", i, m_awvalid);
            end
            @(negedge aclk);
            s_awvalid = 2'b00; s_wvalid = 2'b01; s_wlast = 2'b01;
            @(negedge aclk);
            s_wvalid = 2'b00; s_wlast = 2'b00;
        end
        s_awvalid = 2'b01;
        #1;
        checks++;
        if ({m_awvalid, s_awready, dut.out_cnt_q} !== {1'b0, 2'b00, 3'd4}) begin
            failures++;
            $display("FAIL maxout_block got=v%b r%b cnt%0d exp=v0 r00 cnt4", m_awvalid, s_awready, dut.out_cnt_q);
        end
        @(negedge aclk);
        m_bvalid = 1'b1; m_bid = 6'd0; s_bready = 2'b01;
        #1;
        checks++;
        if (m_awvalid !== 1'b0) begin
            failures++;
            $display("FAIL maxout_hold got=%b exp=0", m_awvalid);
        end
        @(negedge aclk);
        m_bvalid = 1'b0; s_bready = 2'b00;
        #1;
        checks++;
        if ({m_awvalid, s_awready} !== {1'b1, 2'b01}) begin
            failures++;
            $display("FAIL maxout_release got=v%b r%b exp=v1 r01", m_awvalid, s_awready);
        end
        @(negedge aclk);
        s_awvalid = 2'b00; s_wvalid = 2'b01; s_wlast = 2'b01;
        @(negedge aclk);
        s_wvalid = 2'b00; s_wlast = 2'b00;
        m_bvalid = 1'b1; m_bid = 6'd0; s_bready = 2'b01;
        repeat (4) @(negedge aclk);
        m_bvalid = 1'b0; s_bready = 2'b00;
        #1;
        checks++;
        if (dut.out_cnt_q !== 3'd0) begin
            failures++;
            $display("FAIL maxout_drain got=%0d exp=0", dut.out_cnt_q);
        end
    endtask

    // R routing by rid[0]; AR grant hold under stall and arbitration order.
    task automatic test_read();
        logic exp_id;
        @(negedge aclk);
        m_rid = 6'd1; m_rvalid = 1'b1; m_rdata = 32'hCAFE_0001; m_rresp = 2'b01; m_rlast = 1'b1;
        s_rready = 2'b01;
        #1;
        checks++;
        if ({s_rvalid, m_rready, s_rdata[63:32], s_rresp[3:2], s_rlast[1]} !==
            {2'b10, 1'b0, 32'hCAFE_0001, 2'b01, 1'b1}) begin
            failures++;
            $display("FAIL r_route1 got=v%b rr%b d%h resp%b l%b exp=v10 rr0 dcafe0001 resp01 l1",
                     s_rvalid, m_rready, s_rdata[63:32], s_rresp[3:2], s_rlast[1]);
        end
        @(negedge aclk);
        s_rready = 2'b10;
        #1;
        checks++;
        if (m_rready !== 1'b1) begin
            failures++;
            $display("FAIL r_ready1 got=%b exp=1", m_rready);
        end
        @(negedge aclk);
        m_rid = 6'd0; s_rready = 2'b01;
        #1;
        checks++;
        if ({s_rvalid, m_rready} !== {2'b01, 1'b1}) begin
            failures++;
            $display("FAIL r_route0 got=v%b rr%b exp=v01 rr1", s_rvalid, m_rready);
        end
        @(negedge aclk);
        m_rvalid = 1'b0; s_rready = 2'b00;
        s_araddr = {32'h0000_8000, 32'h0000_4000};
        s_arlen = {8'd1, 8'd2};
        s_arvalid = 2'b10;
        m_arready = 1'b0;
        #1;
        checks++;
        if ({m_arvalid, m_arid, m_araddr, m_arlen, s_arready} !== {1'b1, 6'd1, 32'h8000, 8'd1, 2'b00}) begin
            failures++;
            $display("FAIL ar1 got=v%b id%0d a%h l%0d r%b exp=v1 id1 a8000 l1 r00",
                     m_arvalid, m_arid, m_araddr, m_arlen, s_arready);
        end
        checks++;
        if ({m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arqos} !==
            {3'd2, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0}) begin
            failures++;
            $display("FAIL ar_const got=sz%0d b%0d lk%b c%0d p%0d q%0d exp=sz2 b1 0 0 0 0",
                     m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arqos);
        end
        @(negedge aclk);
        s_arvalid = 2'b11;
        #1;
        checks++;
        if ({m_arid, m_araddr} !== {6'd1, 32'h8000}) begin
            failures++;
            $display("FAIL ar_hold got=id%0d a%h exp=id1 a8000", m_arid, m_araddr);
        end
        @(negedge aclk);
        m_arready = 1'b1;
        #1;
        checks++;
        if ({m_arid, s_arready} !== {6'd1, 2'b10}) begin
            failures++;
            $display("FAIL ar_hs1 got=id%0d r%b exp=id1 r10", m_arid, s_arready);
        end
        @(negedge aclk);
        #1;
        checks++;
        if ({m_arid, s_arready, m_araddr, m_arlen} !== {6'd0, 2'b01, 32'h4000, 8'd2}) begin
            failures++;
            $display("FAIL ar_hs0 got=id%0d r%b a%h l%0d exp=id0 r01 a4000 l2", m_arid, s_arready, m_araddr, m_arlen);
        end
        @(negedge aclk);
`ifdef HP_AXI_ARB_ROUND_ROBIN_EN
        exp_id = 1'b1;
`else
        exp_id = 1'b0;
`endif
        #1;
        checks++;
        if (m_arid !== {5'd0, exp_id}) begin
            failures++;
            $display("FAIL ar_prio got=%0d exp=%0d", m_arid, exp_id);
        end
        @(negedge aclk);
        s_arvalid = 2'b00; m_arready = 1'b0;
    endtask

    // Reset after two beats of an eight-beat burst drops the burst.
    task automatic test_reset_mid_burst();
        @(negedge aclk);
        s_awaddr = {32'h0, 32'h0000_7000};
        s_awlen = {8'd0, 8'd7};
        s_awvalid = 2'b01;
        m_awready = 1'b1;
        @(negedge aclk);
        s_awvalid = 2'b00; s_wvalid = 2'b01; s_wlast = 2'b00; m_wready = 1'b1;
        #1;
        checks++;
        if ({m_wvalid, dut.out_cnt_q} !== {1'b1, 3'd1}) begin
            failures++;
            $display("FAIL rst_burst_pre got=v%b cnt%0d exp=v1 cnt1", m_wvalid, dut.out_cnt_q);
        end
        repeat (2) @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        #1;
        checks++;
        if ({m_wvalid, s_wready, dut.state_q, dut.out_cnt_q} !== {1'b0, 2'b00, W_IDLE, 3'd0}) begin
            failures++;
            $display("FAIL rst_burst got=v%b r%b st%0d cnt%0d exp=v0 r00 st0 cnt0",
                     m_wvalid, s_wready, dut.state_q, dut.out_cnt_q);
        end
        @(negedge aclk);
        #1;
        checks++;
        if ({m_wvalid, m_awvalid} !== 2'b00) begin
            failures++;
            $display("FAIL rst_burst_after got=wv%b awv%b exp=00", m_wvalid, m_awvalid);
        end
        s_wvalid = 2'b00; m_wready = 1'b0; m_awready = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_write_arb();
        test_simultaneous();
        test_b_route();
        test_max_out();
        test_read();
        test_reset_mid_burst();
        repeat (2) @(negedge aclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hp_axi_arbiter.md
HP_AXI_ARBITER -- requirements
Module: hp_axi_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning AXI address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning AXI data width; strobe width is DATA_W/8.
REQ-003 The block SHALL have parameter MAX_OUT, default 4, meaning the maximum number of outstanding write bursts awaiting B.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 aclk  in  1  sole clock; all state updates on its rising edge.
REQ-006 areset  in  1  asynchronous active-high reset.
REQ-007 s_aw{valid,addr,len} in / s_awready out  2x{1,ADDR_W,8} / 2  per-requester write address, packed with requester r at slice r.
REQ-008 s_w{valid,data,strb,last} in / s_wready out  2x{1,DATA_W,DATA_W/8,1} / 2  per-requester write data.
REQ-009 s_b{valid,resp} out / s_bready in  2x{1,2} / 2  per-requester write response.
REQ-010 s_ar{valid,addr,len} in / s_arready out  2x{1,ADDR_W,8} / 2  per-requester read address.
REQ-011 s_r{valid,data,resp,last} out / s_rready in  2x{1,DATA_W,2,1} / 2  per-requester read data.
REQ-012 m_aw*, m_w*, m_b*, m_ar*, m_r*  mixed  HP-port widths, 6-bit IDs  single AXI4 master toward the HP port.

Function
REQ-013 m_awid and m_arid SHALL equal {5'b0, granted requester index}; m_awsize/m_arsize SHALL equal log2(DATA_W/8); burst INCR; lock, cache, prot, qos SHALL be 0.
REQ-014 The write FSM SHALL have states W_IDLE and W_DATA.
REQ-015 In W_IDLE, arbitration SHALL select among asserted s_awvalid; m_awvalid SHALL be asserted combinationally when any request is present and outstanding count < MAX_OUT.
REQ-016 On an m_awvalid&&m_awready handshake, the FSM SHALL latch the grant, pulse s_awready of the granted requester only, and move to W_DATA.
REQ-017 In W_DATA, m_w* SHALL mux the latched requester, s_wready SHALL be asserted only to it, and the other requester's s_wready SHALL be 0.
REQ-018 The FSM SHALL return to W_IDLE on the W handshake with wlast=1; no AW SHALL be issued while in W_DATA.
REQ-019 The outstanding counter SHALL increment on AW handshake and decrement on B handshake; simultaneous events SHALL leave it unchanged; it SHALL never exceed MAX_OUT or underflow.
REQ-020 m_b* SHALL route to requester m_bid[0]; m_bready SHALL equal s_bready[m_bid[0]].
REQ-021 The read side SHALL arbitrate AR each cycle with no FSM and unlimited outstanding bursts; m_r* SHALL route by m_rid[0], m_rready SHALL equal s_rready[m_rid[0]].
REQ-022 An m_awvalid/m_arvalid once asserted SHALL hold its grant and payload until handshake.
REQ-023 Arbitration (write and read, independent pointers) SHALL update only on a handshake.

Reset
REQ-024 On areset: FSM=W_IDLE, outstanding=0, arbitration pointers select requester 0, all valid/ready outputs 0.
REQ-025 Reset mid-burst SHALL abandon the burst with no further W beats issued.

Configuration
REQ-026 With HP_AXI_ARB_ROUND_ROBIN_EN defined, each arbiter SHALL grant round-robin, the last-granted requester having lowest priority next.
REQ-027 Without HP_AXI_ARB_ROUND_ROBIN_EN, requester 0 SHALL have fixed priority and the pointer registers SHALL not exist.

Structure
REQ-028 A shared package SHALL hold the write-state enum, requester count (2) and AXI constants (burst INCR, ID width 6).
REQ-029 One sub-module, hp_axi_rr_arb (2-way arbiter with handshake-gated pointer), SHALL be instantiated for AW and for AR.

Verification
REQ-030 Reset, both requesters idle -> all m_*valid and s_*ready 0, outstanding 0.
REQ-031 Both s_awvalid, len=3, RR enabled -> req0 AW (awid=0), 4 beats of req0 W, then req1 AW (awid=1); no interleaved W.
REQ-032 MAX_OUT=4, m_bvalid held 0, five AWs from req0 -> 4 issued, fifth m_awvalid=0 until one B returns.
REQ-033 m_rid=1, m_rvalid=1, s_rready[1]=0 -> s_rvalid[1]=1, s_rvalid[0]=0, m_rready=0.
REQ-034 AW handshake and B handshake in same cycle at outstanding=2 -> outstanding remains 2.
REQ-035 areset asserted after beat 2 of a len=7 burst -> W_IDLE, m_wvalid=0 next cycle, outstanding 0.
